// File: rtl/gshare_predictor_pkg.sv
// Shared ISA constants and types for the branch direction predictor.
// Holds opcode encodings, predictor mode selectors and immediate-decode helpers.
package gshare_predictor_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] ins_t;
  typedef logic [31:0] data_t;

  localparam int OPCODE_HI = 6;
  localparam int OPCODE_LO = 0;
  typedef logic [OPCODE_HI-OPCODE_LO:0] opcode_t;

  localparam opcode_t OPCODE_JAL = 7'b1101111;
  localparam opcode_t OPCODE_BR  = 7'b1100011;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam int PRED_MODE_BIMODAL = 0;
  localparam int PRED_MODE_GSHARE  = 1;

  typedef enum logic [1:0] {
    INST_JAL,
    INST_BR,
    INST_OTHER
  } inst_class_t;

  function automatic inst_class_t classify(input ins_t inst);
    opcode_t op;
    op = inst[OPCODE_HI:OPCODE_LO];
    if (op == OPCODE_JAL)     return INST_JAL;
    else if (op == OPCODE_BR) return INST_BR;
    else                      return INST_OTHER;
  endfunction

  function automatic data_t j_imm(input ins_t inst);
    return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  function automatic data_t b_imm(input ins_t inst);
    return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/sat_counter_update.sv
// Combinational next value of a W-bit saturating up/down counter.
// Counts up when inc is set, down otherwise; sticks at all-ones and zero.
module sat_counter_update #(
  parameter int W = 2
) (
  input  logic [W-1:0] cnt,
  input  logic         inc,
  output logic [W-1:0] next
);

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    next = cnt;
    if (inc) begin
      if (cnt != '1) next = cnt + W'(1);
    end else begin
      if (cnt != '0) next = cnt - W'(1);
    end
  end

endmodule

// File: rtl/gshare_predictor.sv
// Direction predictor for IF: combinational query through a gshare/bimodal-indexed
// saturating-counter table, speculative GHR with ROB repair, and perf counters.
module gshare_predictor
  import gshare_predictor_pkg::*;
#(
  parameter int CNT_BITS   = 2,
  parameter int INDEX_BITS = 8,
  parameter int HIST_LEN   = 6,
  parameter int MODE       = PRED_MODE_GSHARE,
  parameter int PERF_BITS  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 query_valid,
  input  addr_t                query_pc,
  input  ins_t                 query_inst,
  output logic                 predicted_jump,
  output data_t                predicted_imm,
  output logic [HIST_LEN-1:0]  query_ghr,
  input  logic                 upd_valid,
  input  addr_t                upd_pc,
  input  logic                 upd_taken,
  input  logic [HIST_LEN-1:0]  upd_ghr,
  input  logic                 upd_mispredict,
  output logic [PERF_BITS-1:0] perf_branches,
  output logic [PERF_BITS-1:0] perf_mispredicts
);

  localparam int  ENTRIES    = 1 << INDEX_BITS;
  localparam bit  USE_GSHARE = (MODE != PRED_MODE_BIMODAL);
  localparam logic [CNT_BITS-1:0] CNT_WEAK_TAKEN = CNT_BITS'(1) << (CNT_BITS - 1);

  typedef logic [INDEX_BITS-1:0] idx_t;
  typedef logic [CNT_BITS-1:0]   cnt_t;

  if (HIST_LEN < 1 || HIST_LEN > INDEX_BITS) begin : g_bad_hist
    $error("gshare_predictor: HIST_LEN must be in 1..INDEX_BITS");
  end
  if (CNT_BITS < 1) begin : g_bad_cnt
    $error("gshare_predictor: CNT_BITS must be at least 1");
  end

  cnt_t                pht [ENTRIES];
  logic [HIST_LEN-1:0] spec_ghr;
  logic [HIST_LEN-1:0] ghr_shifted;
  logic [HIST_LEN-1:0] ghr_repaired;

  idx_t        q_idx;
  idx_t        u_idx;
  cnt_t        q_cnt;
  cnt_t        u_cnt_next;
  inst_class_t q_class;

  logic [PERF_BITS-1:0] perf_br_next;
  logic [PERF_BITS-1:0] perf_mp_next;

  // The GHR term is folded in only in gshare mode; bimodal still tracks history.
  assign q_idx = USE_GSHARE ? (query_pc[INDEX_BITS+1:2] ^ idx_t'(spec_ghr))
                            : query_pc[INDEX_BITS+1:2];
  assign u_idx = USE_GSHARE ? (upd_pc[INDEX_BITS+1:2] ^ idx_t'(upd_ghr))
                            : upd_pc[INDEX_BITS+1:2];

  assign q_cnt     = pht[q_idx];
  assign q_class   = classify(query_inst);
  assign query_ghr = spec_ghr;

  always_comb begin
    predicted_jump = FALSE;
    case (q_class)
      INST_JAL: predicted_jump = TRUE;
      INST_BR:  predicted_jump = q_cnt[CNT_BITS-1];
      default:  predicted_jump = FALSE;
    endcase
  end

  assign predicted_imm = (q_class == INST_JAL) ? j_imm(query_inst) : b_imm(query_inst);

  if (HIST_LEN == 1) begin : g_hist_one
    assign ghr_shifted  = predicted_jump;
    assign ghr_repaired = upd_taken;
  end else begin : g_hist_many
    assign ghr_shifted  = {spec_ghr[HIST_LEN-2:0], predicted_jump};
    assign ghr_repaired = {upd_ghr[HIST_LEN-2:0], upd_taken};
  end

  sat_counter_update #(.W(CNT_BITS)) u_pht_update (
    .cnt  (pht[u_idx]),
    .inc  (upd_taken),
    .next (u_cnt_next)
  );

  sat_counter_update #(.W(PERF_BITS)) u_perf_br (
    .cnt  (perf_branches),
    .inc  (TRUE),
    .next (perf_br_next)
  );

  sat_counter_update #(.W(PERF_BITS)) u_perf_mp (
    .cnt  (perf_mispredicts),
    .inc  (TRUE),
    .next (perf_mp_next)
  );

  // NOTE: the table is a register array with a real reset because every entry must
  // come up weakly taken; sequential state is always written with non-blocking <=.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) pht[i] <= CNT_WEAK_TAKEN;
    end else if (upd_valid) begin
      pht[u_idx] <= u_cnt_next;
    end
  end

  // A commit-time repair wins over a same-cycle speculative shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      spec_ghr <= '0;
    end else if (upd_valid && upd_mispredict) begin
      spec_ghr <= ghr_repaired;
    end else if (query_valid && q_class == INST_BR) begin
      spec_ghr <= ghr_shifted;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else if (upd_valid) begin
      perf_branches <= perf_br_next;
      if (upd_mispredict) perf_mispredicts <= perf_mp_next;
    end
  end

  logic unused_pc_bits;
  assign unused_pc_bits = ^{query_pc[31:INDEX_BITS+2], query_pc[1:0],
                            upd_pc[31:INDEX_BITS+2], upd_pc[1:0]};

endmodule
